// File: rtl/rising_edge_det.sv
// rising_edge_det
//   Per-bit synchronous rising-edge detector with an optional input
//   synchronizer chain and a saturating count of edge cycles.
//
// Parameters
//   WIDTH       number of independent input bits
//   SYNC_STAGES synchronizer depth ahead of detection (0..4, 0 = bypass)
//   CNT_W       width of edge_count
//
// Ports
//   clk         sole clock, rising edge
//   resetn      synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   data_in     level inputs to monitor
//   data_out    registered one-cycle pulse per 0->1 transition, per bit
//   any_edge    registered OR of the data_out bits
//   edge_count  saturating count of cycles with any_edge asserted
//   cnt_clr     synchronous clear of edge_count, priority over increment
module rising_edge_det #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             any_edge,
  output logic [CNT_W-1:0] edge_count,
  input  logic             cnt_clr
);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_rise;
  logic             w_any;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_data_out;
  logic             r_any_edge;
  logic [CNT_W-1:0] r_edge_count;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = data_in;
    end else begin : g_sync
      // Not reset: the chain keeps shifting during reset so that it is
      // flushed of X by the time reset is released.
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        r_sync[0] <= data_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_rise = w_s & ~r_prev;
  assign w_any  = |w_rise;

  // History samples through reset, so a level already high at release
  // is treated as old news rather than a fresh edge.
  always_ff @(posedge clk) begin
    r_prev <= w_s;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_data_out   <= '0;
      r_any_edge   <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_data_out <= w_rise;
      r_any_edge <= w_any;
      if (cnt_clr) begin
        r_edge_count <= '0;
      end else if (w_any && (r_edge_count != '1)) begin
        r_edge_count <= r_edge_count + 1'b1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign any_edge   = r_any_edge;
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_rising_edge_det.sv
module tb_rising_edge_det;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // a: WIDTH=1 SYNC=0 CNT_W=8
  logic       din_a = 1'b1;
  logic       dout_a;
  logic       any_a;
  logic [7:0] cnt_a;
  // b: WIDTH=1 SYNC=2 CNT_W=8
  logic       din_b = 1'b0;
  logic       dout_b;
  logic       any_b;
  logic [7:0] cnt_b;
  // c: WIDTH=4 SYNC=0 CNT_W=8
  logic [3:0] din_c = 4'b0000;
  logic [3:0] dout_c;
  logic       any_c;
  logic [7:0] cnt_c;
  // d: WIDTH=1 SYNC=0 CNT_W=2
  logic       din_d = 1'b0;
  logic       clr_d = 1'b0;
  logic       dout_d;
  logic       any_d;
  logic [1:0] cnt_d;

  logic       clr_off = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rising_edge_det #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(8)) u_a (
    .clk(clk), .resetn(rst), .data_in(din_a), .data_out(dout_a),
    .any_edge(any_a), .edge_count(cnt_a), .cnt_clr(clr_off));

  rising_edge_det #(.WIDTH(1), .SYNC_STAGES(2), .CNT_W(8)) u_b (
    .clk(clk), .resetn(rst), .data_in(din_b), .data_out(dout_b),
    .any_edge(any_b), .edge_count(cnt_b), .cnt_clr(clr_off));

  rising_edge_det #(.WIDTH(4), .SYNC_STAGES(0), .CNT_W(8)) u_c (
    .clk(clk), .resetn(rst), .data_in(din_c), .data_out(dout_c),
    .any_edge(any_c), .edge_count(cnt_c), .cnt_clr(clr_off));

  rising_edge_det #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(2)) u_d (
    .clk(clk), .resetn(rst), .data_in(din_d), .data_out(dout_d),
    .any_edge(any_d), .edge_count(cnt_d), .cnt_clr(clr_d));

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with input already high; 3 cycles covers the 2-stage synchronizer.
    rst = 1'b1; din_a = 1'b1;
    tick(); tick(); tick();
    check("rst_dout_a", {31'd0, dout_a}, 32'd0);
    check("rst_cnt_a",  {24'd0, cnt_a},  32'd0);
    check("rst_any_c",  {31'd0, any_c},  32'd0);
    rst = 1'b0;
    tick();
    check("held_high_rel", {31'd0, dout_a}, 32'd0);
    tick();
    check("held_high_after", {31'd0, dout_a}, 32'd0);
    check("held_high_cnt",   {24'd0, cnt_a},  32'd0);

    // Alternating 0,1,0,1,0,1
    din_a = 1'b0; tick(); check("alt0", {31'd0, dout_a}, 32'd0);
    din_a = 1'b1; tick(); check("alt1", {31'd0, dout_a}, 32'd1);
    check("alt1_any", {31'd0, any_a}, 32'd1);
    din_a = 1'b0; tick(); check("alt2", {31'd0, dout_a}, 32'd0);
    din_a = 1'b1; tick(); check("alt3", {31'd0, dout_a}, 32'd1);
    din_a = 1'b0; tick(); check("alt4", {31'd0, dout_a}, 32'd0);
    din_a = 1'b1; tick(); check("alt5", {31'd0, dout_a}, 32'd1);
    check("alt_cnt", {24'd0, cnt_a}, 32'd3);

    // Long level: 0 then 1 for 10 cycles, then fall
    din_a = 1'b0; tick(); check("long_lo", {31'd0, dout_a}, 32'd0);
    din_a = 1'b1; tick(); check("long_rise", {31'd0, dout_a}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("long_hold", {31'd0, dout_a}, 32'd0);
    end
    din_a = 1'b0; tick(); check("long_fall", {31'd0, dout_a}, 32'd0);
    tick();               check("long_fall2", {31'd0, any_a}, 32'd0);
    check("long_cnt", {24'd0, cnt_a}, 32'd4);

    // Synchronizer latency: 2 extra cycles, 1 cycle wide
    check("sync_idle", {31'd0, dout_b}, 32'd0);
    din_b = 1'b1;
    tick(); check("sync_t1", {31'd0, dout_b}, 32'd0);
    tick(); check("sync_t2", {31'd0, dout_b}, 32'd0);
    tick(); check("sync_t3", {31'd0, dout_b}, 32'd1);
    tick(); check("sync_t4", {31'd0, dout_b}, 32'd0);
    check("sync_cnt", {24'd0, cnt_b}, 32'd1);

    // Multi-bit
    din_c = 4'b0000; tick(); check("mb_idle", {28'd0, dout_c}, 32'h0);
    din_c = 4'b0101; tick(); check("mb_0101", {28'd0, dout_c}, 32'h5);
    check("mb_any1", {31'd0, any_c}, 32'd1);
    din_c = 4'b1111; tick(); check("mb_1010", {28'd0, dout_c}, 32'hA);
    check("mb_any2", {31'd0, any_c}, 32'd1);
    tick();
    check("mb_quiet", {28'd0, dout_c}, 32'h0);
    check("mb_any0",  {31'd0, any_c},  32'd0);
    check("mb_cnt",   {24'd0, cnt_c},  32'd2);

    // Counter saturation at 3 with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      din_d = 1'b1; tick();
      check("sat_pulse", {31'd0, dout_d}, 32'd1);
      check("sat_cnt", {30'd0, cnt_d}, (i < 3) ? (i + 1) : 3);
      din_d = 1'b0; tick();
    end
    // Clear in the same cycle as an edge: pulse still fires, count is 0
    clr_d = 1'b1; din_d = 1'b1; tick();
    check("clr_pulse", {31'd0, dout_d}, 32'd1);
    check("clr_cnt",   {30'd0, cnt_d},  32'd0);
    clr_d = 1'b0; tick();
    check("clr_hold", {30'd0, cnt_d}, 32'd0);

    // Reset during an active pulse
    din_d = 1'b0; tick();
    din_d = 1'b1; tick();
    check("mid_pulse", {31'd0, dout_d}, 32'd1);
    check("mid_cnt",   {30'd0, cnt_d},  32'd1);
    rst = 1'b1; tick();
    check("mid_rst_dout", {31'd0, dout_d}, 32'd0);
    check("mid_rst_any",  {31'd0, any_d},  32'd0);
    check("mid_rst_cnt",  {30'd0, cnt_d},  32'd0);

    // Rise sampled during reset is absorbed
    din_d = 1'b0; tick(); tick(); tick();
    din_d = 1'b1; tick();
    rst = 1'b0; tick();
    check("absorb", {31'd0, dout_d}, 32'd0);
    tick();
    check("absorb2", {31'd0, dout_d}, 32'd0);
    // Zero in final reset cycle then rise after release is reported
    din_d = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; din_d = 1'b1; tick();
    check("rel_edge", {31'd0, dout_d}, 32'd1);
    check("rel_cnt",  {30'd0, cnt_d},  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
